// File: rtl/task_map_pkg.sv
// Shared types and default sizes for the task-graph feeder, the mapper and their benches.
// No logic, so no latency.
// No flow control lives here.
package task_map_pkg;

   localparam int NUM_V_DFLT = 4;
   localparam int W_W_DFLT   = 32;
   localparam int IDX_W_DFLT = (NUM_V_DFLT > 1) ? $clog2(NUM_V_DFLT) : 1;
   localparam int APP_W_DFLT = 8;

   typedef logic [W_W_DFLT-1:0] weight_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EMIT = 2'd1,
      END  = 2'd2,
      GAP  = 2'd3
   } strm_state_t;

   // Index width for a given vertex count; a single vertex still needs one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/task_graph_mem.sv
// NUM_V x NUM_V edge-weight store with one config write port and one combinational read port.
// The read is combinational; a write is visible on the read port after the clock edge that commits it.
// No backpressure: a write whose row or column index is out of range is dropped.
module task_graph_mem
   import task_map_pkg::*;
#(
   parameter int NUM_V = NUM_V_DFLT,
   parameter int W_W   = W_W_DFLT,
   parameter int IDX_W = idx_width(NUM_V)
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic             we_i,
   input  logic [IDX_W-1:0] wrow_i,
   input  logic [IDX_W-1:0] wcol_i,
   input  logic [W_W-1:0]   wdata_i,
   input  logic [IDX_W-1:0] rrow_i,
   input  logic [IDX_W-1:0] rcol_i,
   output logic [W_W-1:0]   rdata_o
);

   logic [W_W-1:0] mem_q [NUM_V][NUM_V];
   logic           wr_ok;

   // Indices past the last vertex address nothing, so those writes are discarded.
   assign wr_ok = we_i && (int'(wrow_i) < NUM_V) && (int'(wcol_i) < NUM_V);

   // Storage: cleared by reset, otherwise updated only by accepted config writes.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         for (int r = 0; r < NUM_V; r++) begin
            for (int c = 0; c < NUM_V; c++) begin
               mem_q[r][c] <= '0;
            end
         end
      end else if (wr_ok) begin
         mem_q[wrow_i][wcol_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[rrow_i][rcol_i];

endmodule

// File: rtl/task_graph_streamer.sv
// Streams the stored task graph row-major to task_mapper, repeated num_apps times back to back.
// Entry (0,0) appears one cycle after the start edge; each entry is held 2 cycles; a pass is 2*NUM_V^2+2 cycles.
// No backpressure: the mapper follows the fixed cadence; start and cfg_we are ignored while busy.
module task_graph_streamer
   import task_map_pkg::*;
#(
   parameter int NUM_V = NUM_V_DFLT,
   parameter int W_W   = W_W_DFLT,
   parameter int IDX_W = idx_width(NUM_V),
   parameter int APP_W = APP_W_DFLT
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic             cfg_we,
   input  logic [IDX_W-1:0] cfg_row,
   input  logic [IDX_W-1:0] cfg_col,
   input  logic [W_W-1:0]   cfg_wdata,
   input  logic [APP_W-1:0] num_apps,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic [W_W-1:0]   task_array,
   output logic             root_task,
   output logic [IDX_W-1:0] row,
   output logic [IDX_W-1:0] col,
   output logic             app_end
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_V - 1);

   // FSM and walk state
   strm_state_t      state_q, state_d;
   logic             phase_q, phase_d;
   logic [IDX_W-1:0] row_q, row_d;
   logic [IDX_W-1:0] col_q, col_d;
   logic [APP_W-1:0] pass_q, pass_d;
   logic [APP_W-1:0] apps_q, apps_d;
   logic             root_seen_q, root_seen_d;

   // Output registers
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [W_W-1:0]   task_q, task_d;
   logic             root_q, root_d;
   logic [IDX_W-1:0] orow_q, orow_d;
   logic [IDX_W-1:0] ocol_q, ocol_d;
   logic             app_end_q, app_end_d;

   logic [W_W-1:0]   rd_w;
   logic             mem_we;
   logic             start_ok;
   logic             last_entry;
   logic             last_pass;
   logic             is_root;

   // The matrix may only change while idle, so a pass always sees one consistent graph.
   assign mem_we = cfg_we && (state_q == IDLE);

   task_graph_mem #(
      .NUM_V (NUM_V),
      .W_W   (W_W),
      .IDX_W (IDX_W)
   ) u_mem (
      .clk     (clk),
      .rst_b   (rst_b),
      .we_i    (mem_we),
      .wrow_i  (cfg_row),
      .wcol_i  (cfg_col),
      .wdata_i (cfg_wdata),
      .rrow_i  (row_q),
      .rcol_i  (col_q),
      .rdata_o (rd_w)
   );

   assign start_ok   = start && (num_apps != '0);
   assign last_entry = phase_q && (row_q == LAST_IDX) && (col_q == LAST_IDX);
   // Compare one bit wider so an all-ones repeat count cannot wrap.
   assign last_pass  = (({1'b0, pass_q} + (APP_W+1)'(1)) == {1'b0, apps_q});
   // Root is the first non-zero weight met in the current pass.
   assign is_root    = !root_seen_q && (rd_w != '0);

   // State register.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: one pass is EMIT over every entry, then END, then GAP.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (start_ok)   state_d = EMIT;
         EMIT: if (last_entry) state_d = END;
         END:                  state_d = GAP;
         GAP:  state_d = last_pass ? IDLE : EMIT;
         default:              state_d = IDLE;
      endcase
   end

   // Walk counters: entry phase, row/col position, pass count and root tracking.
   always_comb begin
      phase_d     = phase_q;
      row_d       = row_q;
      col_d       = col_q;
      pass_d      = pass_q;
      apps_d      = apps_q;
      root_seen_d = root_seen_q;
      unique case (state_q)
         IDLE: begin
            if (start_ok) begin
               apps_d      = num_apps;
               pass_d      = '0;
               phase_d     = 1'b0;
               row_d       = '0;
               col_d       = '0;
               root_seen_d = 1'b0;
            end
         end
         EMIT: begin
            phase_d = ~phase_q;
            if (!phase_q && is_root) begin
               root_seen_d = 1'b1;
            end
            if (phase_q) begin
               if (col_q == LAST_IDX) begin
                  col_d = '0;
                  row_d = (row_q == LAST_IDX) ? '0 : row_q + IDX_W'(1);
               end else begin
                  col_d = col_q + IDX_W'(1);
               end
            end
         end
         END: begin
         end
         GAP: begin
            pass_d      = pass_q + APP_W'(1);
            root_seen_d = 1'b0;
         end
         default: begin
         end
      endcase
   end

   // Output logic: registered outputs trail the walk state by one cycle.
   always_comb begin
      busy_d    = (state_d != IDLE);
      done_d    = 1'b0;
      task_d    = '0;
      root_d    = 1'b0;
      orow_d    = orow_q;
      ocol_d    = ocol_q;
      app_end_d = 1'b0;
      unique case (state_q)
         IDLE: begin
         end
         EMIT: begin
            task_d = rd_w;
            orow_d = row_q;
            ocol_d = col_q;
            // The second cycle of an entry repeats the root flag of its first cycle.
            root_d = phase_q ? root_q : is_root;
         end
         END: begin
            app_end_d = 1'b1;
         end
         GAP: begin
            done_d = last_pass;
         end
         default: begin
         end
      endcase
   end

   // Walk and output registers; reset aborts a stream without any end marker.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         phase_q     <= 1'b0;
         row_q       <= '0;
         col_q       <= '0;
         pass_q      <= '0;
         apps_q      <= '0;
         root_seen_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         task_q      <= '0;
         root_q      <= 1'b0;
         orow_q      <= '0;
         ocol_q      <= '0;
         app_end_q   <= 1'b0;
      end else begin
         phase_q     <= phase_d;
         row_q       <= row_d;
         col_q       <= col_d;
         pass_q      <= pass_d;
         apps_q      <= apps_d;
         root_seen_q <= root_seen_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         task_q      <= task_d;
         root_q      <= root_d;
         orow_q      <= orow_d;
         ocol_q      <= ocol_d;
         app_end_q   <= app_end_d;
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign task_array = task_q;
   assign root_task  = root_q;
   assign row        = orow_q;
   assign col        = ocol_q;
   assign app_end    = app_end_q;

endmodule

// File: tb/tb_task_graph_streamer.sv
module tb_task_graph_streamer;

   localparam int NV   = 4;
   localparam int WW   = 32;
   localparam int IW   = 2;
   localparam int AW   = 8;
   localparam int PASS = 2*NV*NV + 2;

   logic          clk = 1'b0;
   logic          rst_b = 1'b1;
   logic          cfg_we = 1'b0;
   logic [IW-1:0] cfg_row = '0;
   logic [IW-1:0] cfg_col = '0;
   logic [WW-1:0] cfg_wdata = '0;
   logic [AW-1:0] num_apps = '0;
   logic          start = 1'b0;
   logic          busy, done, root_task, app_end;
   logic [WW-1:0] task_array;
   logic [IW-1:0] row, col;

   task_graph_streamer dut (
      .clk        (clk),
      .rst_b      (rst_b),
      .cfg_we     (cfg_we),
      .cfg_row    (cfg_row),
      .cfg_col    (cfg_col),
      .cfg_wdata  (cfg_wdata),
      .num_apps   (num_apps),
      .start      (start),
      .busy       (busy),
      .done       (done),
      .task_array (task_array),
      .root_task  (root_task),
      .row        (row),
      .col        (col),
      .app_end    (app_end)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference copy of the graph as the DUT should hold it.
   logic [31:0] mdl [NV][NV];

   // Busy-time write issued by run_stream (must be ignored by the DUT).
   int          bw_r = 0;
   int          bw_c = 0;
   logic [31:0] bw_d = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic mdl_clear();
      for (int r = 0; r < NV; r++)
         for (int c = 0; c < NV; c++)
            mdl[r][c] = '0;
   endtask

   // Row-major index of the first non-zero weight, -1 for an empty graph.
   function automatic int first_nz();
      for (int e = 0; e < NV*NV; e++)
         if (mdl[e/NV][e%NV] != 0) return e;
      return -1;
   endfunction

   task automatic load(input int r, input int c, input logic [31:0] d);
      @(negedge clk);
      cfg_we = 1'b1; cfg_row = IW'(r); cfg_col = IW'(c); cfg_wdata = d;
      mdl[r][c] = d;
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   task automatic check_all_zero(input string pfx);
      check({pfx, "_busy"}, 32'(busy), 0);
      check({pfx, "_done"}, 32'(done), 0);
      check({pfx, "_task"}, task_array, 0);
      check({pfx, "_root"}, 32'(root_task), 0);
      check({pfx, "_row"}, 32'(row), 0);
      check({pfx, "_col"}, 32'(col), 0);
      check({pfx, "_aend"}, 32'(app_end), 0);
   endtask

   // Start n passes and compare every cycle against the pass-timing rules.
   // rst_cyc/busy_we_cyc/restart_cyc < 0 disable those events.
   task automatic run_stream(input int n, input int rst_cyc, input bit same_we,
                             input int wr, input int wc, input logic [31:0] wd,
                             input int busy_we_cyc, input int restart_cyc);
      int          fnz, total, pos, e, e_row, e_col;
      logic [31:0] e_task;
      bit          e_root, e_ae, e_busy, e_done, chk_rc;
      int          aend_cnt, root_cnt, done_cnt;
      aend_cnt = 0; root_cnt = 0; done_cnt = 0;
      @(negedge clk);
      start = 1'b1; num_apps = AW'(n);
      if (same_we) begin
         cfg_we = 1'b1; cfg_row = IW'(wr); cfg_col = IW'(wc); cfg_wdata = wd;
         mdl[wr][wc] = wd;
      end
      fnz   = first_nz();
      total = n * PASS;
      for (int c = 0; c <= total + 1; c++) begin
         @(negedge clk);
         start = 1'b0; cfg_we = 1'b0;
         if (c == rst_cyc) begin
            rst_b = 1'b0;
            #1;
            check_all_zero($sformatf("abort_c%0d", c));
            mdl_clear();
            @(negedge clk); @(negedge clk);
            rst_b = 1'b1;
            return;
         end
         e_task = '0; e_root = 0; e_ae = 0; e_done = 0; chk_rc = 0; e_row = 0; e_col = 0;
         if (c < total) begin
            e_busy = 1;
            pos = c % PASS;
            if (pos >= 1 && pos <= 2*NV*NV) begin
               e      = (pos - 1) / 2;
               e_row  = e / NV;
               e_col  = e % NV;
               e_task = mdl[e_row][e_col];
               e_root = (e == fnz);
               chk_rc = 1;
            end else if (pos == PASS - 1) begin
               e_ae = 1; e_row = NV-1; e_col = NV-1; chk_rc = 1;
            end
         end else begin
            e_busy = 0;
            e_done = (c == total);
         end
         check($sformatf("busy_c%0d", c), 32'(busy), 32'(e_busy));
         check($sformatf("done_c%0d", c), 32'(done), 32'(e_done));
         check($sformatf("task_c%0d", c), task_array, e_task);
         check($sformatf("root_c%0d", c), 32'(root_task), 32'(e_root));
         check($sformatf("aend_c%0d", c), 32'(app_end), 32'(e_ae));
         if (chk_rc) begin
            check($sformatf("row_c%0d", c), 32'(row), 32'(e_row));
            check($sformatf("col_c%0d", c), 32'(col), 32'(e_col));
         end
         aend_cnt += int'(app_end);
         root_cnt += int'(root_task);
         done_cnt += int'(done);
         if (c == busy_we_cyc) begin
            cfg_we = 1'b1; cfg_row = IW'(bw_r); cfg_col = IW'(bw_c); cfg_wdata = bw_d;
         end
         if (c == restart_cyc) begin
            start = 1'b1; num_apps = AW'($urandom_range(1, 255));
         end
      end
      check("aend_count", 32'(aend_cnt), 32'(n));
      check("root_count", 32'(root_cnt), (fnz >= 0) ? 32'(2*n) : 32'd0);
      check("done_count", 32'(done_cnt), 32'd1);
   endtask

   task automatic load_test_graph();
      load(0, 1, 5); load(1, 0, 5);
      load(1, 2, 6); load(2, 1, 6);
      load(0, 3, 7); load(3, 0, 7);
   endtask

   initial begin
      mdl_clear();
      #2 rst_b = 1'b0;
      #1 check_all_zero("reset");
      #20;
      @(negedge clk);
      rst_b = 1'b1;

      // Reference graph, single pass then three passes.
      load_test_graph();
      run_stream(1, -1, 0, 0, 0, 0, -1, -1);
      run_stream(3, -1, 0, 0, 0, 0, -1, 40);

      // Empty graph after reset.
      rst_b = 1'b0;
      @(negedge clk);
      rst_b = 1'b1;
      mdl_clear();
      run_stream(1, -1, 0, 0, 0, 0, -1, -1);

      // Write while busy is dropped, same write while idle lands, write+start same cycle.
      load_test_graph();
      bw_r = 2; bw_c = 2; bw_d = 9;
      run_stream(1, -1, 0, 0, 0, 0, 10, -1);
      load(2, 2, 9);
      run_stream(1, -1, 0, 0, 0, 0, -1, -1);
      run_stream(1, -1, 1, 0, 0, 3, -1, -1);

      // start with a zero repeat count is ignored.
      @(negedge clk);
      start = 1'b1; num_apps = '0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         start = 1'b0;
         check($sformatf("zapp_busy%0d", i), 32'(busy), 0);
         check($sformatf("zapp_task%0d", i), task_array, 0);
      end

      // Reset while entry (1,2) is on the outputs, then restart streams zeros.
      run_stream(2, 1 + 2*(1*NV + 2), 0, 0, 0, 0, -1, -1);
      run_stream(1, -1, 0, 0, 0, 0, -1, -1);

      // Randomized graphs, repeat counts, busy-time writes and stray starts.
      for (int t = 0; t < 6; t++) begin
         int n;
         for (int r = 0; r < NV; r++)
            for (int c = 0; c < NV; c++)
               load(r, c, ($urandom_range(0, 2) == 0) ? $urandom : 32'd0);
         n = $urandom_range(1, 3);
         bw_r = $urandom_range(0, NV-1); bw_c = $urandom_range(0, NV-1); bw_d = $urandom | 32'd1;
         run_stream(n, -1, ($urandom_range(0, 1) == 1), $urandom_range(0, NV-1),
                    $urandom_range(0, NV-1), $urandom,
                    $urandom_range(0, n*PASS - 1), $urandom_range(0, n*PASS - 1));
      end

      // Largest repeat count must complete without the pass counter wrapping.
      run_stream(255, -1, 0, 0, 0, 0, -1, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
